// File: rtl/bound_flasher_param.sv
// bound_flasher_param: six-phase thermometer LED flasher with kick-back, hold and loop
module bound_flasher_param #(
    parameter int N_LED = 16,
    parameter int C1    = 6,
    parameter int C2    = 11,
    parameter int C3    = 5,
    parameter int K_LO  = 1,
    parameter int K_HI  = 6,
    localparam int CW   = $clog2(N_LED + 1)
) (
    input  logic             div_clk,
    input  logic             rst,
    input  logic             flk,
    input  logic             hold,
    input  logic             loop,
    output logic [N_LED-1:0] out,
    output logic [CW-1:0]    count,
    output logic [2:0]       phase,
    output logic             busy,
    output logic             done
);
    typedef enum logic [2:0] {IDLE, UP1, DN1, UP2, DN2, UP3, DN3} phase_t;

    localparam logic [CW-1:0] TOP  = CW'(N_LED);
    localparam logic [CW-1:0] T1   = CW'(C1);
    localparam logic [CW-1:0] T2   = CW'(C2);
    localparam logic [CW-1:0] T3   = CW'(C3);
    localparam logic [CW-1:0] KLO  = CW'(K_LO);
    localparam logic [CW-1:0] KHI  = CW'(K_HI);
    localparam logic [CW-1:0] ZERO = '0;

    if (!(0 < C3 && C3 < C1 && C1 < C2 && C2 < N_LED && 0 < K_LO && K_LO < K_HI && K_HI < C2)) begin : g_bad_params
        $error("bound_flasher_param: illegal parameter set");
    end

    phase_t          ph, ph_n;
    logic [CW-1:0]   cnt_n, up, dn;
    logic            done_n, kick;

    assign up    = count + 1'b1;
    assign dn    = count - 1'b1;
    assign kick  = flk && ((ph == UP2 && (count == KLO || count == KHI)) || (ph == UP3 && count == T1));
    assign phase = ph;
    assign busy  = ph != IDLE;

    // next phase/count: kick-back beats the normal step, hold freezes everything
    always_comb begin
        ph_n   = ph;
        cnt_n  = count;
        done_n = 1'b0;
        if (!hold) begin
            case (ph)
                IDLE: ph_n = flk ? UP1 : IDLE;
                UP1: begin
                    cnt_n = up;
                    ph_n  = up == T1 ? DN1 : UP1;
                end
                DN1: begin
                    cnt_n = dn;
                    ph_n  = dn == ZERO ? UP2 : DN1;
                end
                UP2: begin
                    cnt_n = kick ? dn : up;
                    ph_n  = kick ? (dn == ZERO ? UP2 : DN1) : (up == T2 ? DN2 : UP2);
                end
                DN2: begin
                    cnt_n = dn;
                    ph_n  = dn == T3 ? UP3 : DN2;
                end
                UP3: begin
                    cnt_n = kick ? dn : up;
                    ph_n  = kick ? (dn == T3 ? UP3 : DN2) : (up == TOP ? DN3 : UP3);
                end
                DN3: begin
                    cnt_n  = dn;
                    ph_n   = dn == ZERO ? (loop ? UP1 : IDLE) : DN3;
                    done_n = dn == ZERO;
                end
                default: ph_n = IDLE;
            endcase
        end
    end

    // state registers with synchronous active-low reset
    always_ff @(posedge div_clk) begin
        if (!rst) begin
            ph    <= IDLE;
            count <= '0;
            done  <= 1'b0;
        end else begin
            ph    <= ph_n;
            count <= cnt_n;
            done  <= done_n;
        end
    end

    // thermometer decode of the lit count
    always_comb begin
        out = '0;
        for (int i = 0; i < N_LED; i++) out[i] = count > CW'(i);
    end
endmodule

// File: tb/tb_bound_flasher_param.sv
// tb_bound_flasher_param: scoreboard bench for default and small-parameter flashers
module tb_bound_flasher_param;
    typedef struct {
        int    ph;
        int    cnt;
        bit    dn;
        string tag;
    } exp_t;

    localparam int IDLE = 0, UP1 = 1, DN1 = 2, UP2 = 3, DN2 = 4, UP3 = 5, DN3 = 6;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst [2];
    logic flk [2];
    logic hold[2];
    logic loop[2];

    logic [15:0] out0;
    logic [4:0]  cnt0;
    logic [2:0]  ph0;
    logic        busy0, done0;
    logic [7:0]  out1;
    logic [3:0]  cnt1;
    logic [2:0]  ph1;
    logic        busy1, done1;

    exp_t  q0[$];
    exp_t  q1[$];
    int    errors = 0;
    int    checks = 0;
    string sect = "init";

    bound_flasher_param dut0 (
        .div_clk(clk), .rst(rst[0]), .flk(flk[0]), .hold(hold[0]), .loop(loop[0]),
        .out(out0), .count(cnt0), .phase(ph0), .busy(busy0), .done(done0)
    );

    bound_flasher_param #(.N_LED(8), .C1(3), .C2(6), .C3(2), .K_LO(1), .K_HI(3)) dut1 (
        .div_clk(clk), .rst(rst[1]), .flk(flk[1]), .hold(hold[1]), .loop(loop[1]),
        .out(out1), .count(cnt1), .phase(ph1), .busy(busy1), .done(done1)
    );

    task automatic chk(input string who, input exp_t e, input logic [31:0] ph, input logic [31:0] cnt,
                       input logic dn, input logic bs, input logic [31:0] o, input int n);
        logic [31:0] eo;
        logic        eb;
        eo = (32'd1 << e.cnt) - 32'd1;
        eb = e.ph != IDLE;
        checks++;
        assert (cnt <= n) else begin
            errors++;
            $display("FAIL %s/%s wrap: count=%0d above %0d", who, e.tag, cnt, n);
        end
        if (ph !== e.ph || cnt !== e.cnt || dn !== e.dn || bs !== eb || o !== eo) begin
            errors++;
            $display("FAIL %s/%s: got ph=%0d cnt=%0d done=%0b busy=%0b out=%h, want ph=%0d cnt=%0d done=%0b busy=%0b out=%h",
                     who, e.tag, ph, cnt, dn, bs, o, e.ph, e.cnt, e.dn, eb, eo);
        end
    endtask

    // monitor: after every edge, compare each DUT against its oldest pending expectation
    always @(posedge clk) begin
        exp_t e;
        #1;
        if (q0.size() > 0) begin
            e = q0.pop_front();
            chk("dflt", e, 32'(ph0), 32'(cnt0), done0, busy0, 32'(out0), 16);
        end
        if (q1.size() > 0) begin
            e = q1.pop_front();
            chk("var", e, 32'(ph1), 32'(cnt1), done1, busy1, 32'(out1), 8);
        end
    end

    task automatic step(input int d, input logic r, input logic f, input logic h, input logic l,
                        input int ph, input int cnt, input bit dn);
        exp_t e;
        rst[d]  = r;
        flk[d]  = f;
        hold[d] = h;
        loop[d] = l;
        e.ph  = ph;
        e.cnt = cnt;
        e.dn  = dn;
        e.tag = sect;
        if (d == 0) q0.push_back(e);
        else q1.push_back(e);
        @(negedge clk);
    endtask

    task automatic seg(input int d, input int ph, input int ph_end, input int from, input int to,
                       input bit dn_end = 1'b0, input logic l = 1'b0);
        int dir;
        dir = to > from ? 1 : -1;
        for (int c = from + dir; c != to + dir; c += dir)
            step(d, 1'b1, 1'b0, 1'b0, l, c == to ? ph_end : ph, c, dn_end && c == to);
    endtask

    initial begin
        for (int i = 0; i < 2; i++) begin
            rst[i] = 1'b0; flk[i] = 1'b0; hold[i] = 1'b0; loop[i] = 1'b0;
        end
        @(negedge clk);
        sect = "reset_init";
        repeat (2) step(0, 1'b0, 1'b0, 1'b0, 1'b0, IDLE, 0, 1'b0);

        sect = "default";
        step(0, 1'b1, 1'b1, 1'b0, 1'b0, UP1, 0, 1'b0);
        seg(0, UP1, DN1, 0, 6);
        seg(0, DN1, UP2, 6, 0);
        seg(0, UP2, DN2, 0, 11);
        seg(0, DN2, UP3, 11, 5);
        seg(0, UP3, DN3, 5, 16);
        seg(0, DN3, IDLE, 16, 0, 1'b1);
        repeat (2) step(0, 1'b1, 1'b0, 1'b0, 1'b0, IDLE, 0, 1'b0);

        sect = "kick_up2";
        step(0, 1'b1, 1'b1, 1'b0, 1'b0, UP1, 0, 1'b0);
        seg(0, UP1, DN1, 0, 6);
        seg(0, DN1, UP2, 6, 0);
        seg(0, UP2, UP2, 0, 6);
        step(0, 1'b1, 1'b1, 1'b0, 1'b0, DN1, 5, 1'b0);
        seg(0, DN1, UP2, 5, 0);
        step(0, 1'b1, 1'b0, 1'b0, 1'b0, UP2, 1, 1'b0);
        step(0, 1'b1, 1'b1, 1'b0, 1'b0, UP2, 0, 1'b0);
        seg(0, UP2, DN2, 0, 11);
        seg(0, DN2, UP3, 11, 5);
        sect = "kick_up3";
        seg(0, UP3, UP3, 5, 6);
        step(0, 1'b1, 1'b1, 1'b0, 1'b0, UP3, 5, 1'b0);
        seg(0, UP3, UP3, 5, 7);
        step(0, 1'b1, 1'b1, 1'b0, 1'b0, UP3, 8, 1'b0);
        seg(0, UP3, DN3, 8, 16);
        seg(0, DN3, IDLE, 16, 0, 1'b1);
        step(0, 1'b1, 1'b0, 1'b0, 1'b0, IDLE, 0, 1'b0);

        sect = "hold_loop";
        step(0, 1'b1, 1'b1, 1'b0, 1'b0, UP1, 0, 1'b0);
        seg(0, UP1, DN1, 0, 6);
        seg(0, DN1, UP2, 6, 0);
        seg(0, UP2, DN2, 0, 11);
        seg(0, DN2, DN2, 11, 8);
        repeat (5) step(0, 1'b1, 1'b1, 1'b1, 1'b0, DN2, 8, 1'b0);
        step(0, 1'b1, 1'b0, 1'b0, 1'b0, DN2, 7, 1'b0);
        seg(0, DN2, UP3, 7, 5);
        seg(0, UP3, DN3, 5, 16);
        seg(0, DN3, UP1, 16, 0, 1'b1, 1'b1);
        step(0, 1'b1, 1'b0, 1'b0, 1'b1, UP1, 1, 1'b0);

        sect = "reset_mid";
        seg(0, UP1, DN1, 1, 6);
        seg(0, DN1, UP2, 6, 0);
        seg(0, UP2, DN2, 0, 11);
        seg(0, DN2, UP3, 11, 5);
        seg(0, UP3, UP3, 5, 9);
        repeat (2) step(0, 1'b0, 1'b1, 1'b1, 1'b0, IDLE, 0, 1'b0);
        step(0, 1'b1, 1'b0, 1'b0, 1'b0, IDLE, 0, 1'b0);

        sect = "variant";
        step(1, 1'b0, 1'b0, 1'b0, 1'b0, IDLE, 0, 1'b0);
        step(1, 1'b1, 1'b1, 1'b0, 1'b0, UP1, 0, 1'b0);
        seg(1, UP1, DN1, 0, 3);
        seg(1, DN1, UP2, 3, 0);
        seg(1, UP2, DN2, 0, 6);
        seg(1, DN2, UP3, 6, 2);
        seg(1, UP3, DN3, 2, 8);
        seg(1, DN3, IDLE, 8, 0, 1'b1);
        step(1, 1'b1, 1'b0, 1'b0, 1'b0, IDLE, 0, 1'b0);

        repeat (2) @(negedge clk);
        checks++;
        if (q0.size() + q1.size() != 0) begin
            errors++;
            $display("FAIL drain: pending=%0d, want 0", q0.size() + q1.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
